lsmitll_ndrot_bank: RTL and testbench
=====================================

# lsmitll_ndrot_bank

Parametrised, multi-channel, clocked behavioural model of the NDROT (non-destructive readout with toggle output) RSFQ cell. It provides WIDTH independent set/reset storage channels that share one readout pulse line. Each set channel toggles its output after a programmable latency. The block checks critical-timing windows per channel in clock cycles and reports violations through sticky flags and a saturating counter, so no output is forced unknown. It sits in the cell-library simulation flow, where a cycle-accurate register bank replaces arrays of single-bit event-driven cell models.

## Interface
- WIDTH, 4, number of channels (≥1)
- DELAY, 3, readout-to-output latency in cycles (≥1)
- CT_BA, 2, cycles after an accepted b pulse in state 0 during which a is illegal (0 = no window)
- CT_AB, 1, cycles after an a pulse in state 1 during which b is illegal
- CT_RD, 3, cycles after an effective readout during which rd is illegal for that channel
- ERRCNT_W, 8, error counter width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- a  in  WIDTH  per-channel set pulses, edge-encoded (each transition is one pulse)
- b  in  WIDTH  per-channel reset pulses, edge-encoded
- rd  in  1  shared readout pulse, edge-encoded
- err_clr  in  1  synchronous clear of viol and err_cnt
- q  out  WIDTH  per-channel outputs, edge-encoded (each toggle is one output pulse)
- viol  out  WIDTH  sticky per-channel violation flags
- err_cnt  out  ERRCNT_W  count of cycles containing ≥1 violation, saturating

## Operation
- Pulse detection: history registers a_d, b_d and rd_d. A pulse is recognised at edge k when the input differs from its history at that edge. History is updated every edge.
- Arm: the armed flag is cleared by reset. On the first edge after reset release, history loads the inputs, no pulses are recognised, and armed is set to 1.
- Per-channel state st: 0 = clear, 1 = set. Counters win_a, win_b and win_rd load CT on trigger and otherwise decrement to 0. A load overrides the decrement. A window is active when its counter ≠ 0.
- All decisions at an edge use st and counters as they were before that edge.
- a pulse:
  - if win_a ≠ 0, it is a violation.
  - else, st=0 → st=1.
  - else, st=1 → win_b=CT_AB, st unchanged.
- b pulse:
  - if win_b ≠ 0, it is a violation.
  - else, st=1 → st=0.
  - else, st=0 → win_a=CT_BA.
- a and b on the same channel at the same edge: violation. Both pulses are ignored and st is unchanged.
- rd pulse, per channel:
  - st=1 and win_rd=0: schedule a q toggle and load win_rd=CT_RD.
  - st=1 and win_rd≠0: violation, no toggle.
  - st=0: no effect.
  - rd is evaluated against pre-edge st, so an a or b pulse at the same edge does not affect that readout.
- Violation: the offending event is ignored, viol[i] is set, and err_cnt increments once per cycle (not once per channel) and saturates at all-ones.
- err_clr at an edge zeroes viol and err_cnt. A violation at the same edge wins: viol bit = 1, err_cnt = 1.
- Toggle pipeline: DELAY−1 stages of WIDTH-bit toggle vectors feed q ^= vector. Pipeline contents always advance, independent of later state changes.

## Timing
- Reset (async assert, held): q, viol, err_cnt, st, all counters, pipeline, history and armed are all 0. In-flight toggles are discarded.
- Recovery: rst_n deasserts synchronously to clk. The first edge after release is the arm edge.
- Readout latency: rd recognised at edge k → q[i] toggles at edge k+DELAY−1 (DELAY=1 means the same edge).
- Window: loaded at edge k → pulses at edges k+1..k+CT are illegal, and edge k+CT+1 is legal.
- Throughput: one readout per channel every CT_RD+1 cycles. Set and reset are accepted every cycle outside their windows.

## Test plan
- Reset with all inputs 0, then idle for 20 cycles → q=0, viol=0, err_cnt=0.
- (WIDTH=4, DELAY=3) a[0] pulse at edge 10, rd at 14 → q[0] rises at 16, q[3:1] stay 0. rd at 20 → q[0] falls at 22. b[0] at 24, rd at 28 → no toggle.
- Channel 0 set, rd at 14 and 16 → q[0] toggles once (edge 16), viol=4'b0001, err_cnt=1. rd at 18 → legal, toggle at 20.
- b[1] at 10 (st=0), a[1] at 12 → violation, st stays 0, viol[1]=1. a[1] at 13 → accepted, then rd at 15 → q[1] toggles at 17.
- a[2] and b[2] at the same edge → viol[2]=1, err_cnt+1, st unchanged. err_clr next cycle → viol=0, err_cnt=0. Saturation check with ERRCNT_W=2: 5 violating cycles → err_cnt=3.
- rd at edge 30 with channel 3 set, rst_n low at edge 31 → q=0 and stays 0 after release; the toggle due at 32 never appears.

Source files
------------

// File: rtl/lsmitll_ndrot_bank.sv
// Multi-channel NDROT cell model: per-channel set/reset storage, shared readout,
// programmable readout latency and per-channel critical-timing window checks.
module lsmitll_ndrot_bank #(
  parameter int WIDTH    = 4,
  parameter int DELAY    = 3,
  parameter int CT_BA    = 2,
  parameter int CT_AB    = 1,
  parameter int CT_RD    = 3,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                rd,
  input  logic                err_clr,
  output logic [WIDTH-1:0]    q,
  output logic [WIDTH-1:0]    viol,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int CT_MAX1 = (CT_BA > CT_AB) ? CT_BA : CT_AB;
  localparam int CT_MAX  = (CT_MAX1 > CT_RD) ? CT_MAX1 : CT_RD;
  localparam int CW      = (CT_MAX < 1) ? 1 : $clog2(CT_MAX + 1);
  localparam logic [CW-1:0] CT_BA_V = CW'(CT_BA);
  localparam logic [CW-1:0] CT_AB_V = CW'(CT_AB);
  localparam logic [CW-1:0] CT_RD_V = CW'(CT_RD);

  logic [WIDTH-1:0]    a_d_reg, b_d_reg;
  logic                rd_d_reg, armed_reg;
  logic [WIDTH-1:0]    a_pulse, b_pulse;
  logic                rd_pulse;
  logic [WIDTH-1:0]    viol_now, tog_now, tog_out;
  logic [WIDTH-1:0]    q_reg, viol_reg;
  logic [ERRCNT_W-1:0] err_reg;
  logic                any_viol;

  // Edge-encoded inputs: a pulse is any difference from the previous sample,
  // suppressed on the arm edge so post-reset input levels are not misread.
  assign a_pulse  = armed_reg ? (a ^ a_d_reg) : '0;
  assign b_pulse  = armed_reg ? (b ^ b_d_reg) : '0;
  assign rd_pulse = armed_reg & (rd ^ rd_d_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_d_reg   <= '0;
      b_d_reg   <= '0;
      rd_d_reg  <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      a_d_reg   <= a;
      b_d_reg   <= b;
      rd_d_reg  <= rd;
      armed_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    logic          st_reg, st_next;
    logic [CW-1:0] win_a_reg, win_a_next;
    logic [CW-1:0] win_b_reg, win_b_next;
    logic [CW-1:0] win_rd_reg, win_rd_next;
    logic          ch_viol, ch_tog;

    always_comb begin
      st_next     = st_reg;
      win_a_next  = (win_a_reg  != '0) ? win_a_reg  - CW'(1) : '0;
      win_b_next  = (win_b_reg  != '0) ? win_b_reg  - CW'(1) : '0;
      win_rd_next = (win_rd_reg != '0) ? win_rd_reg - CW'(1) : '0;
      ch_viol     = 1'b0;
      ch_tog      = 1'b0;
      if (a_pulse[gi] && b_pulse[gi]) begin
        ch_viol = 1'b1;
      end else if (a_pulse[gi]) begin
        if (win_a_reg != '0)  ch_viol = 1'b1;
        else if (!st_reg)     st_next = 1'b1;
        else                  win_b_next = CT_AB_V;
      end else if (b_pulse[gi]) begin
        if (win_b_reg != '0)  ch_viol = 1'b1;
        else if (st_reg)      st_next = 1'b0;
        else                  win_a_next = CT_BA_V;
      end
      // Readout is judged on the pre-edge state, independent of a/b above.
      if (rd_pulse && st_reg) begin
        if (win_rd_reg != '0) begin
          ch_viol = 1'b1;
        end else begin
          ch_tog      = 1'b1;
          win_rd_next = CT_RD_V;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_reg     <= 1'b0;
        win_a_reg  <= '0;
        win_b_reg  <= '0;
        win_rd_reg <= '0;
      end else begin
        st_reg     <= st_next;
        win_a_reg  <= win_a_next;
        win_b_reg  <= win_b_next;
        win_rd_reg <= win_rd_next;
      end
    end

    assign viol_now[gi] = ch_viol;
    assign tog_now[gi]  = ch_tog;
  end

  if (DELAY == 1) begin : g_nopipe
    assign tog_out = tog_now;
  end else begin : g_pipe
    logic [WIDTH-1:0] pipe_reg [DELAY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < DELAY - 1; s++) pipe_reg[s] <= '0;
      end else begin
        pipe_reg[0] <= tog_now;
        for (int s = 1; s < DELAY - 1; s++) pipe_reg[s] <= pipe_reg[s-1];
      end
    end

    assign tog_out = pipe_reg[DELAY-2];
  end

  assign any_viol = |viol_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg    <= '0;
      viol_reg <= '0;
      err_reg  <= '0;
    end else begin
      q_reg    <= q_reg ^ tog_out;
      viol_reg <= (err_clr ? '0 : viol_reg) | viol_now;
      // A violation in the same cycle as a clear leaves a count of one.
      if (any_viol) begin
        if (err_clr)             err_reg <= ERRCNT_W'(1);
        else if (~&err_reg)      err_reg <= err_reg + ERRCNT_W'(1);
      end else if (err_clr) begin
        err_reg <= '0;
      end
    end
  end

  assign q       = q_reg;
  assign viol    = viol_reg;
  assign err_cnt = err_reg;

endmodule

// File: tb/tb_lsmitll_ndrot_bank.sv
// Bench for lsmitll_ndrot_bank: directed vector table, hand sequences for
// saturation and reset-in-flight, then random pulses against an event model.
module tb_lsmitll_ndrot_bank;
  localparam int W   = 4;
  localparam int DL  = 3;
  localparam int CBA = 2;
  localparam int CAB = 1;
  localparam int CRD = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         rd = 1'b0, err_clr = 1'b0;
  logic [W-1:0] q, viol, q2, viol2;
  logic [7:0]   err_cnt;
  logic [1:0]   err2;

  int n_chk = 0;
  int n_bad = 0;

  lsmitll_ndrot_bank dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .rd(rd), .err_clr(err_clr),
    .q(q), .viol(viol), .err_cnt(err_cnt)
  );

  lsmitll_ndrot_bank #(.ERRCNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .rd(rd), .err_clr(err_clr),
    .q(q2), .viol(viol2), .err_cnt(err2)
  );

  always #5 clk = ~clk;

  // Event model: windows as absolute "illegal up to edge" numbers, toggles as
  // a schedule keyed by the edge they land on.
  int           e = 0;
  bit           m_armed;
  logic [W-1:0] pa_l, pb_l;
  logic         prd_l;
  bit           m_st [W];
  int           ua [W], ub [W], urd [W];
  logic [W-1:0] m_q, m_viol;
  int           m_err;
  logic [W-1:0] due [int];

  task automatic model_reset();
    m_armed = 0;
    pa_l = '0; pb_l = '0; prd_l = 1'b0;
    for (int i = 0; i < W; i++) begin
      m_st[i] = 0; ua[i] = -1; ub[i] = -1; urd[i] = -1;
    end
    m_q = '0; m_viol = '0; m_err = 0;
    due.delete();
  endtask

  task automatic model_edge();
    logic [W-1:0] ap, bp, vnow, t;
    bit rp, s0;
    int k;
    e++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ap = m_armed ? (a ^ pa_l) : '0;
    bp = m_armed ? (b ^ pb_l) : '0;
    rp = m_armed ? (rd ^ prd_l) : 1'b0;
    m_armed = 1; pa_l = a; pb_l = b; prd_l = rd;
    vnow = '0;
    for (int i = 0; i < W; i++) begin
      s0 = m_st[i];
      if (rp && s0) begin
        if (e <= urd[i]) vnow[i] = 1'b1;
        else begin
          k = e + DL - 1;
          t = due.exists(k) ? due[k] : '0;
          t[i] = ~t[i];
          due[k] = t;
          urd[i] = e + CRD;
        end
      end
      if (ap[i] && bp[i]) vnow[i] = 1'b1;
      else if (ap[i]) begin
        if (e <= ua[i]) vnow[i] = 1'b1;
        else if (!s0) m_st[i] = 1;
        else ub[i] = e + CAB;
      end else if (bp[i]) begin
        if (e <= ub[i]) vnow[i] = 1'b1;
        else if (s0) m_st[i] = 0;
        else ua[i] = e + CBA;
      end
    end
    if (err_clr) begin m_viol = '0; m_err = 0; end
    m_viol |= vnow;
    if (vnow != '0) m_err++;
    if (due.exists(e)) begin
      m_q ^= due[e];
      due.delete(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse(input logic [W-1:0] ap, input logic [W-1:0] bp,
                       input logic rp, input logic clr);
    a = a ^ ap; b = b ^ bp; rd = rd ^ rp; err_clr = clr;
    step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".q"}, {28'd0, q}, {28'd0, m_q});
    check({tag, ".viol"}, {28'd0, viol}, {28'd0, m_viol});
    check({tag, ".err"}, {24'd0, err_cnt}, sat(m_err, 255));
    check({tag, ".q2"}, {28'd0, q2}, {28'd0, m_q});
    check({tag, ".viol2"}, {28'd0, viol2}, {28'd0, m_viol});
    check({tag, ".err2"}, {30'd0, err2}, sat(m_err, 3));
  endtask

  typedef struct {
    logic [W-1:0] ap, bp;
    logic         rp, clr;
    logic [W-1:0] eq, ev;
    logic [7:0]   ee;
  } vec_t;

  vec_t tbl [24];
  logic [W-1:0] rap, rbp;

  initial begin
    tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'd0};
    tbl[1]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'd0};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'd0};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'd0};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0001, 8'd1};
    tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001, 8'd1};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0001, 8'd1};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0000, 8'd0};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'd0};
    tbl[9]  = '{4'b0010, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'd0};
    tbl[10] = '{4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 8'd0};
    tbl[11] = '{4'b0000, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0010, 8'd1};
    tbl[12] = '{4'b0000, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0010, 8'd1};
    tbl[13] = '{4'b0000, 4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0010, 8'd1};
    tbl[14] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0110, 8'd2};
    tbl[15] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0110, 8'd3};
    tbl[16] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0110, 8'd3};
    tbl[17] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0110, 8'd3};
    tbl[18] = '{4'b1000, 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b1110, 8'd4};
    tbl[19] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0100, 4'b0001, 8'd1};
    tbl[20] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0001, 8'd1};
    tbl[21] = '{4'b0000, 4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0001, 8'd1};
    tbl[22] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0001, 8'd1};
    tbl[23] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001, 8'd1};

    model_reset();
    repeat (3) step();
    check("reset.q", {28'd0, q}, 32'd0);
    check("reset.viol", {28'd0, viol}, 32'd0);
    check("reset.err", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    step();
    repeat (20) step();
    check("idle.q", {28'd0, q}, 32'd0);
    check("idle.viol", {28'd0, viol}, 32'd0);
    check("idle.err", {24'd0, err_cnt}, 32'd0);

    for (int r = 0; r < 24; r++) begin
      pulse(tbl[r].ap, tbl[r].bp, tbl[r].rp, tbl[r].clr);
      check($sformatf("tbl%0d.q", r), {28'd0, q}, {28'd0, tbl[r].eq});
      check($sformatf("tbl%0d.viol", r), {28'd0, viol}, {28'd0, tbl[r].ev});
      check($sformatf("tbl%0d.err", r), {24'd0, err_cnt}, {24'd0, tbl[r].ee});
    end

    // Saturation: 8-bit counter keeps counting, 2-bit one sticks at 3.
    pulse('0, '0, 1'b0, 1'b1);
    check("sat.clr", {24'd0, err_cnt}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      pulse(4'b0001, 4'b0001, 1'b0, 1'b0);
      check($sformatf("sat%0d.err", k), {24'd0, err_cnt}, k);
      check($sformatf("sat%0d.err2", k), {30'd0, err2}, sat(k, 3));
    end

    // Reset lands while a toggle for channel 3 is in flight.
    pulse(4'b1000, '0, 1'b0, 1'b0);
    pulse('0, '0, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rstfl.q", {28'd0, q}, 32'd0);
    check("rstfl.viol", {28'd0, viol}, 32'd0);
    check("rstfl.err", {24'd0, err_cnt}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rstfl_post%0d.q", k), {28'd0, q}, 32'd0);
    end

    for (int c = 0; c < 400; c++) begin
      rap = '0; rbp = '0;
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 4) == 0) rap[i] = 1'b1;
        if ($urandom_range(0, 4) == 0) rbp[i] = 1'b1;
      end
      pulse(rap, rbp, ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0));
      check_model($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
